// File: rtl/dram_responder_pkg.sv
// rtl/dram_responder_pkg.sv - shared mode encodings and word width for the DRAM path
package dram_responder_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [3:0] {
    MODE_BCAST = 4'd0,
    MODE_RD1   = 4'd1,
    MODE_RD2   = 4'd2,
    MODE_RD3   = 4'd3,
    MODE_RD4   = 4'd4,
    MODE_WR1   = 4'd5,
    MODE_WR2   = 4'd6,
    MODE_WR3   = 4'd7,
    MODE_WR4   = 4'd8,
    MODE_IDLE  = 4'hF
  } mode_e;

  // Core index 0-3 for core 1-4; broadcast and idle map to 0.
  function automatic logic [1:0] core_of(input logic [3:0] m);
    logic [3:0] d;
    d = 4'd0;
    if (m >= MODE_WR1 && m <= MODE_WR4)
      d = m - MODE_WR1;
    else if (m >= MODE_RD1 && m <= MODE_RD4)
      d = m - MODE_RD1;
    return d[1:0];
  endfunction

endpackage

// File: rtl/dram_responder_array.sv
// rtl/dram_responder_array.sv - single-port word storage with registered read, block-RAM friendly
module dram_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // No reset on storage or read register so both map onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_en)
      mem[addr] <= wr_data;
    if (rd_en)
      rd_data <= mem[addr];
  end

endmodule

// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - memory-side responder: decodes the registered mode and services reads/writes
module dram_responder
  import dram_responder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = dram_responder_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        mode,
  input  logic              end_process2,
  input  logic              end_process3,
  input  logic              end_process4,
  input  logic [15:0]       ar_out,
  input  logic [DATA_W-1:0] bus_out,
  output logic [DATA_W-1:0] dram_out,
  output logic              rd_valid,
  output logic              wr_ack,
  output logic              addr_err,
  output logic [1:0]        last_core,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  logic [3:0]        mode_d;
  logic [2:0]        endp_d;
  logic              is_rd, is_wr, in_range, rd_en, wr_en;
  logic              zero_q;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    is_rd    = 1'b0;
    is_wr    = 1'b0;
    in_range = ((ar_out >> ADDR_W) == 16'd0);
    case (mode_d)
      MODE_BCAST, MODE_RD1, MODE_RD2, MODE_RD3, MODE_RD4: is_rd = 1'b1;
      MODE_WR1: is_wr = 1'b1;
      MODE_WR2: is_wr = !endp_d[0];
      MODE_WR3: is_wr = !endp_d[1];
      MODE_WR4: is_wr = !endp_d[2];
      default: ;
    endcase
    // Reset flushes whatever access is sitting in the mode_d stage.
    rd_en = is_rd && in_range && !reset;
    wr_en = is_wr && in_range && !reset;
  end

  dram_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clock   (clock),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .addr    (ar_out[ADDR_W-1:0]),
    .wr_data (bus_out),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_d    <= MODE_IDLE;
      endp_d    <= 3'b000;
      zero_q    <= 1'b1;
      rd_valid  <= 1'b0;
      wr_ack    <= 1'b0;
      addr_err  <= 1'b0;
      last_core <= 2'd0;
      rd_count  <= 16'd0;
      wr_count  <= 16'd0;
    end else begin
      mode_d   <= mode;
      endp_d   <= {end_process4, end_process3, end_process2};
      rd_valid <= is_rd;
      wr_ack   <= wr_en;
      addr_err <= (is_rd || is_wr) && !in_range;
      if (is_rd)
        zero_q <= !in_range;
      if (rd_en)
        rd_count <= rd_count + 16'd1;
      if (wr_en)
        wr_count <= wr_count + 16'd1;
      if (rd_en || wr_en)
        last_core <= core_of(mode_d);
    end
  end

  // The read register lives in the array; out-of-range reads and reset mask it to zero.
  assign dram_out = zero_q ? '0 : rd_data;

endmodule

// File: tb/tb_dram_responder.sv
// tb/tb_dram_responder.sv - directed self-checking bench for dram_responder
module tb_dram_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  mode;
  logic        end_process2, end_process3, end_process4;
  logic [15:0] ar_out, bus_out;
  logic [15:0] dram_out;
  logic        rd_valid, wr_ack, addr_err;
  logic [1:0]  last_core;
  logic [15:0] rd_count, wr_count;

  int checks = 0;
  int failures = 0;

  dram_responder #(.ADDR_W(8), .DATA_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .mode         (mode),
    .end_process2 (end_process2),
    .end_process3 (end_process3),
    .end_process4 (end_process4),
    .ar_out       (ar_out),
    .bus_out      (bus_out),
    .dram_out     (dram_out),
    .rd_valid     (rd_valid),
    .wr_ack       (wr_ack),
    .addr_err     (addr_err),
    .last_core    (last_core),
    .rd_count     (rd_count),
    .wr_count     (wr_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // mode in one cycle, registered address/data in the next; pulses visible on return.
  task automatic issue(input logic [3:0] m, input logic [15:0] a, input logic [15:0] d);
    mode = m;
    step();
    mode = 4'hF;
    ar_out = a;
    bus_out = d;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mode = 4'hF;
    end_process2 = 1'b0; end_process3 = 1'b0; end_process4 = 1'b0;
    ar_out = 16'h0; bus_out = 16'h0;
    step(); step();
    reset = 1'b0;
    step();
    checks++; if (dram_out !== 16'h0000) begin failures++; $display("FAIL reset_dram_out got=%h exp=0000", dram_out); end
    checks++; if ({rd_valid, wr_ack, addr_err} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {rd_valid, wr_ack, addr_err}); end
    checks++; if (last_core !== 2'd0) begin failures++; $display("FAIL reset_last_core got=%0d exp=0", last_core); end
    checks++; if (rd_count !== 16'd0 || wr_count !== 16'd0) begin failures++; $display("FAIL reset_counts got=%h/%h exp=0000/0000", rd_count, wr_count); end
    checks++; if (dut.mode_d !== 4'hF) begin failures++; $display("FAIL reset_mode_d got=%h exp=f", dut.mode_d); end
  endtask

  task automatic test_write_read();
    issue(4'd5, 16'h0012, 16'hBEEF);
    checks++; if (wr_ack !== 1'b1) begin failures++; $display("FAIL wr_ack_pulse got=%b exp=1", wr_ack); end
    checks++; if (wr_count !== 16'd1) begin failures++; $display("FAIL wr_count got=%0d exp=1", wr_count); end
    step();
    checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL wr_ack_one_cycle got=%b exp=0", wr_ack); end
    issue(4'd1, 16'h0012, 16'h0000);
    checks++; if (rd_valid !== 1'b1 || dram_out !== 16'hBEEF) begin failures++; $display("FAIL read_back got=%b/%h exp=1/beef", rd_valid, dram_out); end
    checks++; if (rd_count !== 16'd1) begin failures++; $display("FAIL rd_count got=%0d exp=1", rd_count); end
    step();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rd_valid_one_cycle got=%b exp=0", rd_valid); end
  endtask

  task automatic test_gated_write();
    issue(4'd8, 16'h0005, 16'h5555);
    checks++; if (wr_ack !== 1'b1 || last_core !== 2'd3) begin failures++; $display("FAIL core4_write got=%b/%0d exp=1/3", wr_ack, last_core); end
    end_process3 = 1'b1;
    issue(4'd7, 16'h0005, 16'h1234);
    end_process3 = 1'b0;
    checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL gated_wr_ack got=%b exp=0", wr_ack); end
    checks++; if (wr_count !== 16'd2 || last_core !== 2'd3) begin failures++; $display("FAIL gated_state got=%0d/%0d exp=2/3", wr_count, last_core); end
    issue(4'd2, 16'h0005, 16'h0000);
    checks++; if (dram_out !== 16'h5555 || last_core !== 2'd1) begin failures++; $display("FAIL gated_readback got=%h/%0d exp=5555/1", dram_out, last_core); end
  endtask

  task automatic test_out_of_range();
    issue(4'd2, 16'h0100, 16'h0000);
    checks++; if (addr_err !== 1'b1 || rd_valid !== 1'b1) begin failures++; $display("FAIL oor_read_pulses got=%b/%b exp=1/1", addr_err, rd_valid); end
    checks++; if (dram_out !== 16'h0000) begin failures++; $display("FAIL oor_read_data got=%h exp=0000", dram_out); end
    checks++; if (rd_count !== 16'd2 || last_core !== 2'd1) begin failures++; $display("FAIL oor_read_state got=%0d/%0d exp=2/1", rd_count, last_core); end
    issue(4'd5, 16'h0205, 16'h9999);
    checks++; if (addr_err !== 1'b1 || wr_ack !== 1'b0 || wr_count !== 16'd2) begin failures++; $display("FAIL oor_write got=%b/%b/%0d exp=1/0/2", addr_err, wr_ack, wr_count); end
    issue(4'd3, 16'h0005, 16'h0000);
    checks++; if (dram_out !== 16'h5555 || addr_err !== 1'b0) begin failures++; $display("FAIL oor_write_alias got=%h/%b exp=5555/0", dram_out, addr_err); end
  endtask

  task automatic test_back_to_back();
    mode = 4'd6;
    step();
    ar_out = 16'h0040; bus_out = 16'h0A0A; mode = 4'd3;
    step();
    checks++; if (wr_ack !== 1'b1 || last_core !== 2'd1) begin failures++; $display("FAIL b2b_write got=%b/%0d exp=1/1", wr_ack, last_core); end
    mode = 4'hF;
    step();
    checks++; if (rd_valid !== 1'b1 || dram_out !== 16'h0A0A || last_core !== 2'd2) begin failures++; $display("FAIL b2b_read got=%b/%h/%0d exp=1/0a0a/2", rd_valid, dram_out, last_core); end
  endtask

  task automatic test_idle_hold();
    issue(4'd5, 16'h0033, 16'hA5A5);
    issue(4'd0, 16'h0033, 16'h0000);
    checks++; if (dram_out !== 16'hA5A5 || last_core !== 2'd0) begin failures++; $display("FAIL bcast_read got=%h/%0d exp=a5a5/0", dram_out, last_core); end
    mode = 4'd12;
    ar_out = 16'h0012;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (dram_out !== 16'hA5A5 || {rd_valid, wr_ack, addr_err} !== 3'b000) begin failures++; $display("FAIL idle_hold_%0d got=%h/%b exp=a5a5/000", i, dram_out, {rd_valid, wr_ack, addr_err}); end
    end
    mode = 4'hF;
    step();
  endtask

  task automatic test_reset_mid();
    issue(4'd5, 16'h0060, 16'h7777);
    mode = 4'd6;
    step();
    ar_out = 16'h0060; bus_out = 16'hDEAD; mode = 4'hF; reset = 1'b1;
    step();
    checks++; if (wr_ack !== 1'b0 || dut.mode_d !== 4'hF) begin failures++; $display("FAIL midreset_state got=%b/%h exp=0/f", wr_ack, dut.mode_d); end
    checks++; if (dram_out !== 16'h0 || rd_count !== 16'h0 || wr_count !== 16'h0 || last_core !== 2'd0) begin failures++; $display("FAIL midreset_outputs got=%h/%h/%h/%0d exp=0/0/0/0", dram_out, rd_count, wr_count, last_core); end
    reset = 1'b0;
    step();
    checks++; if ({rd_valid, wr_ack, addr_err} !== 3'b000) begin failures++; $display("FAIL midreset_no_pulse got=%b exp=000", {rd_valid, wr_ack, addr_err}); end
    issue(4'd4, 16'h0060, 16'h0000);
    checks++; if (dram_out !== 16'h7777) begin failures++; $display("FAIL midreset_memory got=%h exp=7777", dram_out); end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    step();
    reset = 1'b0;
    ar_out = 16'h0001; bus_out = 16'h1111; mode = 4'd5;
    step();
    repeat (65534) step();
    mode = 4'hF;
    step();
    checks++; if (wr_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=ffff", wr_count); end
    issue(4'd5, 16'h0002, 16'h2222);
    checks++; if (wr_count !== 16'h0000 || wr_ack !== 1'b1) begin failures++; $display("FAIL wrap_count got=%h/%b exp=0000/1", wr_count, wr_ack); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_gated_write();
    test_out_of_range();
    test_back_to_back();
    test_idle_hold();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
